// File: rtl/collision_detect.sv
// Scans obstacle records one per clk3 tick and latches game-over on the first
// axis-aligned bounding-box overlap with the player record.
module collision_detect #(
    parameter int unsigned OBJ_NUM     = 4,
    parameter int unsigned TW          = 3,
    parameter int unsigned XW          = 10,
    parameter int unsigned YW          = 10,
    parameter int unsigned WW          = 8,
    parameter int unsigned HW          = 8,
    parameter int unsigned DATALEN     = TW + XW + YW + WW + HW,
    parameter int unsigned PLAYER_TYPE = 1,
    parameter int unsigned EMPTY_TYPE  = 0,
    parameter int unsigned IDXW        = 2
) (
    input  logic                       clk3,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       pause,
    input  logic [DATALEN-1:0]         player,
    input  logic [OBJ_NUM*DATALEN-1:0] obstacles,
    output logic                       gameover,
    output logic [IDXW-1:0]            hit_index,
    output logic                       scan_done,
    output logic                       busy
);

    localparam int unsigned XO  = TW;
    localparam int unsigned YO  = TW + XW;
    localparam int unsigned WO  = TW + XW + YW;
    localparam int unsigned HO  = TW + XW + YW + WW;
    localparam int unsigned SXW = ((XW > WW) ? XW : WW) + 1;
    localparam int unsigned SYW = ((YW > HW) ? YW : HW) + 1;

    typedef enum logic [1:0] {StIdle, StScan, StOver} state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              gameover_q, gameover_d;
    logic [IDXW-1:0]   hit_index_q, hit_index_d;
    logic              scan_done_q, scan_done_d;
    logic              busy_q, busy_d;

    logic [DATALEN-1:0] obs;
    logic [SXW-1:0]     px, pw, ox, ow;
    logic [SYW-1:0]     py, ph, oy, oh;
    logic               player_ok, hit, last;

    assign obs = obstacles[32'(idx_q) * DATALEN +: DATALEN];

    // Zero-extend so the edge sums cannot wrap.
    assign px = SXW'(player[XO +: XW]);
    assign pw = SXW'(player[WO +: WW]);
    assign py = SYW'(player[YO +: YW]);
    assign ph = SYW'(player[HO +: HW]);
    assign ox = SXW'(obs[XO +: XW]);
    assign ow = SXW'(obs[WO +: WW]);
    assign oy = SYW'(obs[YO +: YW]);
    assign oh = SYW'(obs[HO +: HW]);

    assign player_ok = (player[TW-1:0] == TW'(PLAYER_TYPE));
    assign last      = (idx_q == IDXW'(OBJ_NUM - 1));

    // Strict inequalities: touching edges never count, and a zero-sized
    // obstacle is rejected explicitly since the strict test alone admits it.
    assign hit = (obs[TW-1:0] != TW'(EMPTY_TYPE)) && (ow != '0) && (oh != '0) &&
                 (px < ox + ow) && (ox < px + pw) && (py < oy + oh) && (oy < py + ph);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gameover_d  = gameover_q;
        hit_index_d = hit_index_q;
        scan_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                idx_d = '0;
                if (start && !pause && player_ok) begin
                    state_d = StScan;
                end
            end
            StScan: begin
                if (!start) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else if (!pause) begin
                    if (hit) begin
                        state_d     = StOver;
                        gameover_d  = 1'b1;
                        hit_index_d = idx_q;
                    end else if (last) begin
                        idx_d       = '0;
                        scan_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
            end
            StOver: begin
                if (!start) begin
                    state_d    = StIdle;
                    gameover_d = 1'b0;
                    idx_d      = '0;
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
        busy_d = (state_d == StScan);
    end

    always_ff @(posedge clk3) begin
        if (!reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            gameover_q  <= 1'b0;
            hit_index_q <= '0;
            scan_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gameover_q  <= gameover_d;
            hit_index_q <= hit_index_d;
            scan_done_q <= scan_done_d;
            busy_q      <= busy_d;
        end
    end

    assign gameover  = gameover_q;
    assign hit_index = hit_index_q;
    assign scan_done = scan_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_collision_detect.sv
// Directed and randomized checks of collision_detect against a cycle-level
// behavioural model of the scan/game-over rules.
module tb_collision_detect;

    localparam int NOBJ = 4;
    localparam int DL   = 39;

    logic                 clk3 = 1'b0;
    logic                 reset, start, pause;
    logic [DL-1:0]        player;
    logic [DL-1:0]        obs [NOBJ];
    logic [NOBJ*DL-1:0]   obstacles;
    logic                 gameover, scan_done, busy;
    logic [1:0]           hit_index;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state
    bit m_run, m_over, m_done;
    int m_idx, m_hit;

    assign obstacles = {obs[3], obs[2], obs[1], obs[0]};

    always #5 clk3 = ~clk3;

    collision_detect dut (
        .clk3      (clk3),
        .reset     (reset),
        .start     (start),
        .pause     (pause),
        .player    (player),
        .obstacles (obstacles),
        .gameover  (gameover),
        .hit_index (hit_index),
        .scan_done (scan_done),
        .busy      (busy)
    );

    function automatic logic [DL-1:0] mk(int t, int x, int y, int w, int h);
        return {8'(h), 8'(w), 10'(y), 10'(x), 3'(t)};
    endfunction

    function automatic bit overlaps(logic [DL-1:0] p, logic [DL-1:0] o);
        int px = int'(p[12:3]);
        int py = int'(p[22:13]);
        int pw = int'(p[30:23]);
        int ph = int'(p[38:31]);
        int ox = int'(o[12:3]);
        int oy = int'(o[22:13]);
        int ow = int'(o[30:23]);
        int oh = int'(o[38:31]);
        if (o[2:0] == 3'd0 || ow == 0 || oh == 0) return 1'b0;
        return (px < ox + ow) && (ox < px + pw) && (py < oy + oh) && (oy < py + ph);
    endfunction

    task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance the model by one edge from the current inputs, clock the DUT, compare.
    task automatic tick();
        m_done = 1'b0;
        if (!reset) begin
            m_run = 0; m_over = 0; m_idx = 0; m_hit = 0;
        end else if (m_over) begin
            if (!start) begin
                m_over = 0; m_idx = 0;
            end
        end else if (!m_run) begin
            m_idx = 0;
            if (start && !pause && player[2:0] == 3'd1) m_run = 1;
        end else if (!start) begin
            m_run = 0; m_idx = 0;
        end else if (!pause) begin
            if (overlaps(player, obs[m_idx])) begin
                m_run = 0; m_over = 1; m_hit = m_idx;
            end else if (m_idx == NOBJ - 1) begin
                m_idx = 0; m_done = 1;
            end else begin
                m_idx++;
            end
        end
        @(posedge clk3);
        #1;
        check("gameover", 32'(gameover), 32'(m_over));
        check("hit_index", 32'(hit_index), 32'(m_hit));
        check("scan_done", 32'(scan_done), 32'(m_done));
        check("busy", 32'(busy), 32'(m_run));
        if (!m_over) check("idx", 32'(dut.idx_q), 32'(m_idx));
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic all_far();
        for (int k = 0; k < NOBJ; k++) obs[k] = mk(2, 300, 100, 10, 20);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; pause = 1'b0;
        player = mk(1, 50, 100, 20, 20);
        all_far();
        ticks(2);
        reset = 1'b1;
        ticks(1);

        // Reset mid-scan at idx 2
        start = 1'b1;
        ticks(3);
        check("idx_before_reset", 32'(dut.idx_q), 32'd2);
        reset = 1'b0;
        ticks(1);
        reset = 1'b1;

        // No collision: scan_done every 4 cycles
        ticks(13);

        // Hit on slot 2, then hold through pause toggles
        obs[2] = mk(2, 60, 110, 10, 10);
        ticks(6);
        check("hit_slot2_gameover", 32'(gameover), 32'd1);
        check("hit_slot2_index", 32'(hit_index), 32'd2);
        pause = 1'b1; ticks(2);
        pause = 1'b0; ticks(1);
        pause = 1'b1; ticks(1);
        pause = 1'b0;
        start = 1'b0;
        ticks(1);
        check("exit_over_gameover", 32'(gameover), 32'd0);
        ticks(1);

        // Edge touch (ox == px+pw) then one unit of overlap
        all_far();
        obs[0] = mk(2, 70, 100, 10, 20);
        start = 1'b1;
        ticks(10);
        obs[0] = mk(2, 69, 100, 10, 20);
        ticks(5);
        check("edge_hit_index", 32'(hit_index), 32'd0);
        start = 1'b0; ticks(2);

        // Empty slot with overlapping geometry, plus zero-width obstacle
        all_far();
        obs[1] = mk(0, 55, 105, 10, 10);
        obs[3] = mk(3, 55, 105, 0, 10);
        start = 1'b1;
        ticks(10);

        // Pause at idx 1 for 5 cycles, then resume and hit slot 1
        start = 1'b0; ticks(1);
        all_far();
        start = 1'b1;
        ticks(2);
        pause = 1'b1;
        ticks(5);
        check("pause_idx", 32'(dut.idx_q), 32'd1);
        obs[1] = mk(4, 40, 90, 15, 15);
        pause = 1'b0;
        ticks(1);
        check("resume_hit_index", 32'(hit_index), 32'd1);
        start = 1'b0; ticks(2);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(99) >= 2);
            start = ($urandom_range(99) >= 8);
            pause = ($urandom_range(99) < 15);
            if ($urandom_range(99) < 5)
                player = mk(($urandom_range(9) == 0) ? 2 : 1, $urandom_range(90, 30),
                            $urandom_range(130, 80), $urandom_range(25), $urandom_range(25));
            if ($urandom_range(99) < 25)
                obs[$urandom_range(NOBJ - 1)] = mk($urandom_range(7), $urandom_range(140, 20),
                    $urandom_range(170, 60), $urandom_range(20), $urandom_range(20));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/collision_detect.md
Name: collision_detect

Overview:
- Downstream consumer of the player object record produced by the player-update stage.
- Scans the obstacle object records one per clk3 cycle and tests each against the player with an axis-aligned bounding-box overlap check.
- On the first overlap, latches game-over and the index of the obstacle that was hit.
- Game-over feeds the pause and score logic; it is cleared when the game returns to the title screen.

Parameters:
- OBJ_NUM, 4, number of obstacle records on the obstacles bus.
- TW, 3, type field width.
- XW, 10, x field width.
- YW, 10, y field width.
- WW, 8, width field width.
- HW, 8, height field width.
- DATALEN, TW+XW+YW+WW+HW, record width.
- PLAYER_TYPE, 1, type code of a valid in-game player record.
- EMPTY_TYPE, 0, type code of an unused obstacle slot.
- IDXW, 2, width of hit_index; must satisfy 2^IDXW >= OBJ_NUM.

Ports:
- clk3  in  1  game tick clock.
- reset  in  1  synchronous, active-low reset; sampled only on posedge clk3.
- start  in  1  1 = game running, 0 = title screen.
- pause  in  1  1 = freeze the scan.
- player  in  DATALEN  player record.
- obstacles  in  OBJ_NUM*DATALEN  record k at bits [k*DATALEN +: DATALEN].
- gameover  out  1  sticky collision flag.
- hit_index  out  IDXW  index of the colliding obstacle.
- scan_done  out  1  one-cycle pulse after a full scan with no hit.
- busy  out  1  high while in SCAN.

Behaviour:
- Record layout, LSB first: type [TW-1:0], then x, y, width, height. All fields are unsigned.
- Reset (reset==0 at posedge clk3): state=IDLE, idx=0, gameover=0, hit_index=0, scan_done=0, busy=0. Reset overrides everything, including mid-scan and OVER.
- All outputs are registered.
- States: IDLE, SCAN, OVER.
- IDLE:
  - Go to SCAN with idx=0 when start==1, pause==0 and player.type==PLAYER_TYPE.
  - Otherwise stay in IDLE.
- SCAN, in priority order:
  - start==0: go to IDLE, idx=0.
  - pause==1: hold idx and all outputs; no compare is performed.
  - Otherwise compare obstacle[idx] against the player in the current cycle:
    - Hit (obstacle type != EMPTY_TYPE and overlap): next cycle gameover=1, hit_index=idx, state=OVER.
    - No hit and idx==OBJ_NUM-1: idx wraps to 0, scan_done=1 for exactly one cycle, stay in SCAN (scanning is continuous).
    - No hit otherwise: idx increments by 1.
- Latency: a collision with slot k is flagged at most OBJ_NUM cycles after it first exists, and exactly 1 cycle after slot k is compared.
- OVER:
  - gameover stays 1 and hit_index is frozen. pause is ignored.
  - start==0 moves to IDLE and clears gameover on the same edge; hit_index keeps its value.
- Overlap test is strict on all four edges; shared edges are not a collision:
  - px < ox+ow
  - ox < px+pw
  - py < oy+oh
  - oy < py+ph
- Sums are computed one bit wider than the wider operand, so there is no wrap-around.
- Zero-width or zero-height obstacles can never hit.
- Records are sampled combinationally in the compare cycle only. Changes to non-indexed slots during a scan are legal and are seen on their own turn.
- Only one slot is compared per cycle, so there are no simultaneous hits. Ties across slots resolve in scan order.
- busy=1 exactly when state==SCAN.
- scan_done=0 in every cycle other than the wrap cycle described above.

Test Plan:
- Reset mid-SCAN at idx=2: on the next edge gameover=0, idx=0, busy=0, state=IDLE.
- No collision: player x=50 y=100 w=20 h=20; all 4 obstacles x=300 y=100 w=10 h=20.
  - scan_done pulses every 4 cycles.
  - gameover stays 0.
- Hit on slot 2: slot 2 at x=60 y=110 w=10 h=10.
  - gameover=1 and hit_index=2 exactly 1 cycle after idx==2 is compared.
  - Both hold while start stays 1, and also when pause is toggled.
- Edge-touch: obstacle x=70, player x=50 w=20 (ox == px+pw) -> no hit. Obstacle x=69 -> hit.
- Empty slot: slot 1 has type=EMPTY_TYPE with geometry overlapping the player -> no hit, scan continues.
- Pause and exit:
  - pause=1 at idx=1 for 5 cycles: idx stays 1, no scan_done pulse.
  - After pause=0: resume at slot 1.
  - From OVER, start=0: gameover=0 and state=IDLE on the next edge.
